atm_keypad_front: RTL

Customer-side front panel sequencer that produces the transaction inputs consumed by the ATM controller fsm. It collects keypad strobes (card detect, decimal digits, function keys) and builds the PIN, transaction type, account and amount. It then presents them as one stable, qualified request by asserting bank_card_insert. It is the transmitting end of the fsm input interface and uses the fsm's ready output as its flow control.

---
 rtl/atm_pkg.sv | 34 +++
 rtl/dec_accumulator.sv | 48 ++++
 rtl/atm_keypad_front.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the ATM keypad front panel
package atm_pkg;

  localparam int DATA_W = 14;

  // Function key encodings; 0-9 are decimal digits, 15 is reserved
  typedef enum logic [3:0] {
    KEY_ENTER    = 4'd10,
    KEY_CANCEL   = 4'd11,
    KEY_CLEAR    = 4'd12,
    KEY_DEPOSIT  = 4'd13,
    KEY_WITHDRAW = 4'd14
  } key_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_PIN_ENTRY  = 3'd2,
    ST_SEL_TYPE   = 3'd3,
    ST_SEL_ACCT   = 3'd4,
    ST_AMT_ENTRY  = 3'd5,
    ST_HOLD       = 3'd6
  } state_e;

  localparam logic ACCT_CHEQUING = 1'b0;
  localparam logic ACCT_SAVINGS  = 1'b1;
  localparam logic SEL_WITHDRAW  = 1'b0;
  localparam logic SEL_DEPOSIT   = 1'b1;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// rtl/dec_accumulator.sv - decimal digit accumulator shared by the PIN and amount phases
module dec_accumulator #(
  parameter int DATA_W     = 14,
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              digit_en_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept;

  // Shift-add times ten; DATA_W is sized so MAX_DIGITS nines never overflow
  always_comb begin
    accept  = digit_en_i && (count_q < CNT_W'(MAX_DIGITS));
    acc_d   = acc_q;
    count_d = count_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accept) begin
      acc_d   = (acc_q << 3) + (acc_q << 1) + {{(DATA_W-4){1'b0}}, digit_i};
      count_d = count_q + CNT_W'(1);
    end
  end

  // Accumulator and digit count registers; clear has priority over a digit
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign acc_o   = acc_q;
  assign count_o = count_q;

endmodule

// File: rtl/atm_keypad_front.sv
// rtl/atm_keypad_front.sv - keypad sequencer building the ATM fsm request; optional ATM_TIMEOUT_EN
module atm_keypad_front #(
  parameter int DATA_W         = atm_pkg::DATA_W,
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_detect,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              ready,
  output logic              bank_card_insert,
  output logic [DATA_W-1:0] pin,
  output logic [DATA_W-1:0] amount,
  output logic              deposit_withdrawal_selection,
  output logic              account_selection,
  output logic              busy,
  output logic [2:0]        digit_count
);

  import atm_pkg::*;

  state_e            state_q;
  logic              bci_q, dws_q, acct_q, busy_q;
  logic [DATA_W-1:0] pin_q, amount_q;

  logic [DATA_W-1:0] acc;
  logic [2:0]        acc_count;

  logic key_digit, key_enter, key_cancel, key_clear;
  logic in_entry, past_wait, abort, tmo_expire;
  logic enter_pin_ok, enter_amt_ok, acc_clr, acc_digit;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);

  assign in_entry  = (state_q == ST_PIN_ENTRY) || (state_q == ST_AMT_ENTRY);
  assign past_wait = (state_q != ST_IDLE) && (state_q != ST_WAIT_READY);

  // Card removal beats CANCEL beats everything else; any key in an abort cycle is dropped
  assign abort = ((state_q != ST_IDLE) && !card_detect) || (past_wait && key_cancel) || tmo_expire;

  assign enter_pin_ok = (state_q == ST_PIN_ENTRY) && key_enter && (acc_count != 3'd0);
  assign enter_amt_ok = (state_q == ST_AMT_ENTRY) && key_enter && (acc != '0);

  // Held clear outside the entry states, so every entry into PIN/AMT starts from zero
  assign acc_clr   = !in_entry || abort || key_clear || enter_pin_ok || enter_amt_ok;
  assign acc_digit = in_entry && key_digit;

  dec_accumulator #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS),
    .CNT_W     (3)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (acc_clr),
    .digit_en_i(acc_digit),
    .digit_i   (key_code),
    .acc_o     (acc),
    .count_o   (acc_count)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_counting;

  assign tmo_counting = in_entry || (state_q == ST_SEL_TYPE) || (state_q == ST_SEL_ACCT);
  assign tmo_expire   = tmo_counting && !key_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inactivity counter; moves between entry states are always key-driven, so
  // reloading on keys and outside entry states covers every state change
  always_ff @(posedge clk) begin
    if (rst || !tmo_counting || key_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_expire = 1'b0;
`endif

  // Front panel sequencer with registered request and field outputs
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q  <= ST_IDLE;
      bci_q    <= 1'b0;
      pin_q    <= '0;
      amount_q <= '0;
      dws_q    <= SEL_WITHDRAW;
      acct_q   <= ACCT_CHEQUING;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (card_detect) begin
            state_q <= ST_WAIT_READY;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT_READY: begin
          if (ready) state_q <= ST_PIN_ENTRY;
        end
        ST_PIN_ENTRY: begin
          if (enter_pin_ok) begin
            pin_q   <= acc;
            state_q <= ST_SEL_TYPE;
          end
        end
        ST_SEL_TYPE: begin
          if (key_valid && key_code == KEY_DEPOSIT) begin
            dws_q   <= SEL_DEPOSIT;
            state_q <= ST_SEL_ACCT;
          end else if (key_valid && key_code == KEY_WITHDRAW) begin
            dws_q   <= SEL_WITHDRAW;
            state_q <= ST_SEL_ACCT;
          end
        end
        ST_SEL_ACCT: begin
          if (key_valid && key_code == 4'd0) begin
            acct_q  <= ACCT_CHEQUING;
            state_q <= ST_AMT_ENTRY;
          end else if (key_valid && key_code == 4'd1) begin
            acct_q  <= ACCT_SAVINGS;
            state_q <= ST_AMT_ENTRY;
          end
        end
        ST_AMT_ENTRY: begin
          if (enter_amt_ok) begin
            amount_q <= acc;
            bci_q    <= 1'b1;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          state_q <= ST_HOLD;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bank_card_insert             = bci_q;
  assign pin                          = pin_q;
  assign amount                       = amount_q;
  assign deposit_withdrawal_selection = dws_q;
  assign account_selection            = acct_q;
  assign busy                         = busy_q;
  assign digit_count                  = acc_count;

endmodule
